led_sreg_pwm_driver: RTL
========================

LED_SREG_PWM_DRIVER -- requirements
Module: led_sreg_pwm_driver

Interface
REQ-001 SHALL have parameter COUNT, default 16, LEDs per shift-register chain (>=1).
REQ-002 SHALL have parameter CHAINS, default 1, parallel chains sharing sreg_clk/sreg_ld (>=1).
REQ-003 SHALL have parameter INVERT, default 1, 1 = active-low data (sreg_d = lit XOR INVERT).
REQ-004 SHALL have parameter PRESCALE, default 63, tick period = PRESCALE+1 clk cycles.
REQ-005 SHALL have parameter PWM_WIDTH, default 4, brightness bits per LED (>=1).
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port clk  input  1  sole clock.
REQ-008 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-009 SHALL have port led_en  input  CHAINS*COUNT  per-LED enable; LED n of chain c at bit c*COUNT+n.
REQ-010 SHALL have port led_level  input  CHAINS*COUNT*PWM_WIDTH  per-LED brightness; same index order, PWM_WIDTH bits each.
REQ-011 SHALL have port sreg_d  output  CHAINS  serial data, one bit per chain.
REQ-012 SHALL have port sreg_clk  output  1  shift clock, common to all chains.
REQ-013 SHALL have port sreg_ld  output  1  latch strobe, common to all chains.
REQ-014 SHALL have port frame_start  output  1  one-clk pulse when a new frame snapshot is taken.

Function
REQ-015 SHALL hold a prescale counter 0..PRESCALE incrementing every clk; tick = counter==PRESCALE, counter then wraps to 0.
REQ-016 SHALL advance the state machine and update sreg_d/sreg_clk/sreg_ld only on tick; all outputs registered.
REQ-017 SHALL implement states SHIFT_LO, SHIFT_HI, LATCH with bit index b (COUNT-1 down to 0) and PWM phase p.
REQ-018 SHIFT_LO tick: sreg_clk=0, sreg_ld=0, sreg_d[c]=lit(c,b) XOR INVERT; next SHIFT_HI.
REQ-019 SHIFT_HI tick: sreg_clk=1; if b==0 next LATCH, else b=b-1 and next SHIFT_LO.
REQ-020 LATCH tick: sreg_clk=0, sreg_ld=1; b=COUNT-1; p=p+1, wrapping from 2^PWM_WIDTH-2 to 0; next SHIFT_LO.
REQ-021 Frame SHALL last exactly 2*COUNT+1 ticks; bit COUNT-1 shifted first, bit 0 last.
REQ-022 SHALL snapshot led_en and led_level in the clk of the SHIFT_LO tick with b==COUNT-1, assert frame_start in that same clk, and use only the snapshot for the whole frame.
REQ-023 lit(c,n) SHALL equal en(c,n) AND (level(c,n) > p), unsigned PWM_WIDTH-bit compare.
REQ-024 level 0 SHALL never light; level 2^PWM_WIDTH-1 SHALL light in every frame; level L lit in L of every 2^PWM_WIDTH-1 frames.
REQ-025 Input changes mid-frame SHALL take effect only from the next frame start.
REQ-026 PRESCALE=0 SHALL give a tick every clk with identical sequencing.

Reset
REQ-027 On rst assertion, immediately: sreg_d=0, sreg_clk=0, sreg_ld=0, frame_start=0, prescale=0, state=SHIFT_LO, b=COUNT-1, p=0, snapshot=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no latch pulse; after release the first tick (clk PRESCALE+1) restarts at bit COUNT-1 with p=0.

Verification
REQ-029 COUNT=4, CHAINS=1, INVERT=0, PRESCALE=1, PWM_WIDTH=1, led_en=4'b1010, led_level=4'hF -> frame = 9 ticks = 18 clks; sreg_d sampled on sreg_clk rise = 1,0,1,0; one sreg_ld pulse of 2 clks per frame.
REQ-030 Same config, INVERT=1 -> sampled sreg_d = 0,1,0,1; sreg_ld/sreg_clk unchanged.
REQ-031 CHAINS=2, COUNT=4, PWM_WIDTH=2, led_en=8'hFF, chain0 levels all 0, chain1 levels all 3 -> sreg_d[0] always 0, sreg_d[1] always 1 across 3 frames.
REQ-032 PWM_WIDTH=2, one LED level=1 -> lit in frame p=0 only, dark for p=1,2, pattern repeats every 3 frames; level=2 -> lit p=0,1.
REQ-033 Change led_en mid-frame (after bit COUNT-1 shifted) -> current frame data unchanged; new data appears from next frame; frame_start pulse 1 clk per frame.
REQ-034 Assert rst during SHIFT_HI of bit 1 -> all outputs 0 same cycle, no sreg_ld; after release first sreg_clk rise occurs after 2 ticks and carries bit COUNT-1.

Source files
------------

// File: rtl/led_sreg_pwm_driver.sv
// Serial shift-register LED driver: shifts per-LED PWM-modulated on/off bits out of
// CHAINS parallel chains, one frame per PWM phase, paced by a clk_sys prescaler tick.
//
// state    | meaning
// SHIFT_LO | present bit b on sreg_d with sreg_clk low (bit COUNT-1 also snapshots inputs)
// SHIFT_HI | raise sreg_clk to shift bit b into the chain
// LATCH    | pulse sreg_ld to transfer the chain to its outputs, advance PWM phase
module led_sreg_pwm_driver #(
  parameter int COUNT     = 16,
  parameter int CHAINS    = 1,
  parameter int INVERT    = 1,
  parameter int PRESCALE  = 63,
  parameter int PWM_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHAINS*COUNT-1:0]             led_en,
  input  logic [CHAINS*COUNT*PWM_WIDTH-1:0]   led_level,
  output logic [CHAINS-1:0]                   sreg_d,
  output logic                                sreg_clk,
  output logic                                sreg_ld,
  output logic                                frame_start
);

  localparam int BW  = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int PSW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [BW-1:0]        B_TOP    = BW'(COUNT - 1);
  localparam logic [PSW-1:0]       PS_TOP   = PSW'(PRESCALE);
  localparam logic [PWM_WIDTH-1:0] P_TOP    = PWM_WIDTH'((1 << PWM_WIDTH) - 2);
  localparam logic [CHAINS-1:0]    INV_MASK = (INVERT != 0) ? {CHAINS{1'b1}} : {CHAINS{1'b0}};

  typedef enum logic [1:0] {
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t                              state, state_nxt;
  logic [BW-1:0]                       b, b_nxt;
  logic [PWM_WIDTH-1:0]                p, p_nxt;
  logic [PSW-1:0]                      pre_cnt;
  logic                                tick;
  logic                                first;
  logic                                snap_load;
  logic [CHAINS*COUNT-1:0]             snap_en;
  logic [CHAINS*COUNT*PWM_WIDTH-1:0]   snap_level;
  logic [CHAINS-1:0]                   lit;
  logic [CHAINS-1:0]                   d_nxt;
  logic                                sclk_nxt, ld_nxt, fs_nxt;

  assign tick  = (pre_cnt == PS_TOP);
  assign first = (state == SHIFT_LO) && (b == B_TOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PSW'(1);
  end

  // The first bit of a frame is driven from the live inputs, which are the very
  // values being captured into the snapshot on that same edge.
  for (genvar c = 0; c < CHAINS; c++) begin : g_chain
    logic [COUNT-1:0]     en_c;
    logic [PWM_WIDTH-1:0] lvl_c [COUNT];

    always_comb begin
      en_c = first ? led_en[c*COUNT +: COUNT] : snap_en[c*COUNT +: COUNT];
      for (int n = 0; n < COUNT; n++) begin
        lvl_c[n] = first ? led_level[(c*COUNT+n)*PWM_WIDTH +: PWM_WIDTH]
                         : snap_level[(c*COUNT+n)*PWM_WIDTH +: PWM_WIDTH];
      end
    end

    assign lit[c] = en_c[b] && (lvl_c[b] > p);
  end

  always_comb begin
    state_nxt = state;
    b_nxt     = b;
    p_nxt     = p;
    d_nxt     = sreg_d;
    sclk_nxt  = sreg_clk;
    ld_nxt    = sreg_ld;
    fs_nxt    = 1'b0;
    snap_load = 1'b0;
    if (tick) begin
      case (state)
        SHIFT_LO: begin
          sclk_nxt  = 1'b0;
          ld_nxt    = 1'b0;
          d_nxt     = lit ^ INV_MASK;
          state_nxt = SHIFT_HI;
          if (first) begin
            snap_load = 1'b1;
            fs_nxt    = 1'b1;
          end
        end
        SHIFT_HI: begin
          sclk_nxt = 1'b1;
          if (b == '0) begin
            state_nxt = LATCH;
          end else begin
            b_nxt     = b - BW'(1);
            state_nxt = SHIFT_LO;
          end
        end
        LATCH: begin
          sclk_nxt  = 1'b0;
          ld_nxt    = 1'b1;
          b_nxt     = B_TOP;
          p_nxt     = (p == P_TOP) ? '0 : p + PWM_WIDTH'(1);
          state_nxt = SHIFT_LO;
        end
        default: state_nxt = SHIFT_LO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SHIFT_LO;
      b           <= B_TOP;
      p           <= '0;
      sreg_d      <= '0;
      sreg_clk    <= 1'b0;
      sreg_ld     <= 1'b0;
      frame_start <= 1'b0;
      snap_en     <= '0;
      snap_level  <= '0;
    end else begin
      state       <= state_nxt;
      b           <= b_nxt;
      p           <= p_nxt;
      sreg_d      <= d_nxt;
      sreg_clk    <= sclk_nxt;
      sreg_ld     <= ld_nxt;
      frame_start <= fs_nxt;
      if (snap_load) begin
        snap_en    <= led_en;
        snap_level <= led_level;
      end
    end
  end

endmodule
